// File: rtl/noc_input_port_requester_pkg.sv
// Noc_parameters: shared NoC router types and helpers.
//   flit_type_e - 2-bit flit type carried with each VC buffer head flit
//   port_e      - router output port numbering (bit index of one-hot routes)
//   vc_state_e  - per-VC requester FSM states
//   xy_route()  - dimension-ordered (X first, then Y) route to a one-hot port
package Noc_parameters;

  localparam int Noc_VC_Channel = 4;
  localparam int NUM_PORTS      = 5;

  typedef enum logic [1:0] {
    BODY      = 2'b00,
    HEAD      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    EAST  = 3'd1,
    WEST  = 3'd2,
    NORTH = 3'd3,
    SOUTH = 3'd4
  } port_e;

  typedef enum logic {
    VC_IDLE   = 1'b0,
    VC_ACTIVE = 1'b1
  } vc_state_e;

  // Coordinates are passed zero-extended to 32 bits so the comparison stays
  // unsigned over the caller's full coordinate width.
  function automatic logic [NUM_PORTS-1:0] xy_route(
    input logic [31:0] dest_x,
    input logic [31:0] dest_y,
    input logic [31:0] local_x,
    input logic [31:0] local_y
  );
    logic [NUM_PORTS-1:0] route;
    route = '0;
    if (dest_x > local_x)      route[int'(EAST)]  = 1'b1;
    else if (dest_x < local_x) route[int'(WEST)]  = 1'b1;
    else if (dest_y > local_y) route[int'(NORTH)] = 1'b1;
    else if (dest_y < local_y) route[int'(SOUTH)] = 1'b1;
    else                       route[int'(LOCAL)] = 1'b1;
    return route;
  endfunction

endpackage

// File: rtl/noc_input_port_requester_vc_route_fsm.sv
// noc_vc_route_fsm: per-virtual-channel requester.
// Routes the head flit, holds the packet's output port for the whole packet,
// raises per-flit requests, pops on grant and flags end of packet on the tail.
// Ports:
//   clk, srst            - clock, synchronous active-high reset
//   flit_valid/flit_type - VC buffer head flit status
//   dest_x/dest_y        - head flit destination (used only when routing)
//   grant[5]             - flit grant per output port for this VC
//   flit_pop             - pop the VC buffer head this cycle
//   sop/request/eop/free - one-hot per output port for this VC
//   out_sel              - one-hot crossbar select for this VC
//   err                  - one-cycle protocol error pulse
module noc_vc_route_fsm
  import Noc_parameters::*;
#(
  parameter int COORD_W = 4,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 flit_valid,
  input  logic [1:0]           flit_type,
  input  logic [COORD_W-1:0]   dest_x,
  input  logic [COORD_W-1:0]   dest_y,
  input  logic [NUM_PORTS-1:0] grant,
  output logic                 flit_pop,
  output logic [NUM_PORTS-1:0] sop,
  output logic [NUM_PORTS-1:0] request,
  output logic [NUM_PORTS-1:0] eop,
  output logic [NUM_PORTS-1:0] free,
  output logic [NUM_PORTS-1:0] out_sel,
  output logic                 err
);

  vc_state_e            state_reg, state_next;
  logic [NUM_PORTS-1:0] port_reg, port_next;
  // Set once the packet's own head has been transferred; a later head-type
  // flit in the same packet is a protocol error.
  logic                 head_done_reg, head_done_next;

  logic                 is_head;
  logic                 is_tail;
  logic                 xfer;
  logic [NUM_PORTS-1:0] route;

  assign is_head = flit_type[0];  // HEAD or HEAD_TAIL
  assign is_tail = flit_type[1];  // TAIL or HEAD_TAIL
  assign route   = xy_route(32'(dest_x), 32'(dest_y), 32'(LOCAL_X), 32'(LOCAL_Y));

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg     <= VC_IDLE;
      port_reg      <= '0;
      head_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      port_reg      <= port_next;
      head_done_reg <= head_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    port_next      = port_reg;
    head_done_next = head_done_reg;
    flit_pop       = 1'b0;
    sop            = '0;
    request        = '0;
    eop            = '0;
    free           = '0;
    out_sel        = '0;
    err            = 1'b0;
    xfer           = 1'b0;

    case (state_reg)
      VC_IDLE: begin
        if (flit_valid) begin
          if (is_head) begin
            // Route only; the head itself is transferred from ACTIVE.
            state_next     = VC_ACTIVE;
            port_next      = route;
            head_done_next = 1'b0;
          end else begin
            // Orphan body/tail: drop it.
            flit_pop = 1'b1;
            err      = 1'b1;
          end
        end
      end
      VC_ACTIVE: begin
        sop     = port_reg;
        out_sel = port_reg;
        // request never looks at grant, so no combinational loop is possible.
        request = flit_valid ? port_reg : '0;
        xfer    = flit_valid && (|(grant & port_reg));
        if (xfer) begin
          flit_pop       = 1'b1;
          head_done_next = 1'b1;
          err            = is_head && head_done_reg;
          if (is_tail) begin
            eop        = port_reg;
            free       = port_reg;
            state_next = VC_IDLE;
          end
        end
      end
      default: state_next = VC_IDLE;
    endcase

    // Outputs are quiet while reset is held, independent of the buffer.
    if (srst) begin
      flit_pop = 1'b0;
      sop      = '0;
      request  = '0;
      eop      = '0;
      free     = '0;
      out_sel  = '0;
      err      = 1'b0;
    end
  end

endmodule

// File: rtl/noc_input_port_requester.sv
// noc_input_port_requester: router input-port side of the per-port control
// interface. One noc_vc_route_fsm per VC; this level transposes the per-VC
// one-hot vectors into [port][vc] order and keeps the saturating error count.
// Ports (flattened):
//   noc_clk, noc_rst              - clock, synchronous active-high reset
//   flit_valid_i[vc]              - VC buffer head valid
//   flit_type_i[vc*2 +: 2]        - head flit type
//   dest_x_i/dest_y_i[vc*COORD_W +: COORD_W] - head destination
//   flit_pop_o[vc]                - pop VC buffer head
//   sop_o/request_o/eop_o/free_o/grant_i[port*CHANNELS + vc]
//   out_sel_o[vc*5 +: 5]          - one-hot crossbar select per VC
//   err_o[vc], err_cnt_o          - error pulse per VC, saturating total
module noc_input_port_requester
  import Noc_parameters::*;
#(
  parameter int CHANNELS = Noc_VC_Channel,
  parameter int COORD_W  = 4,
  parameter int LOCAL_X  = 0,
  parameter int LOCAL_Y  = 0
) (
  input  logic                          noc_clk,
  input  logic                          noc_rst,
  input  logic [CHANNELS-1:0]           flit_valid_i,
  input  logic [CHANNELS*2-1:0]         flit_type_i,
  input  logic [CHANNELS*COORD_W-1:0]   dest_x_i,
  input  logic [CHANNELS*COORD_W-1:0]   dest_y_i,
  output logic [CHANNELS-1:0]           flit_pop_o,
  output logic [NUM_PORTS*CHANNELS-1:0] sop_o,
  output logic [NUM_PORTS*CHANNELS-1:0] request_o,
  input  logic [NUM_PORTS*CHANNELS-1:0] grant_i,
  output logic [NUM_PORTS*CHANNELS-1:0] eop_o,
  output logic [NUM_PORTS*CHANNELS-1:0] free_o,
  output logic [CHANNELS*NUM_PORTS-1:0] out_sel_o,
  output logic [CHANNELS-1:0]           err_o,
  output logic [7:0]                    err_cnt_o
);

  logic [NUM_PORTS-1:0] grant_vc   [CHANNELS];
  logic [NUM_PORTS-1:0] sop_vc     [CHANNELS];
  logic [NUM_PORTS-1:0] request_vc [CHANNELS];
  logic [NUM_PORTS-1:0] eop_vc     [CHANNELS];
  logic [NUM_PORTS-1:0] free_vc    [CHANNELS];
  logic [CHANNELS-1:0]  err_vc;

  logic [7:0]  cnt_reg, cnt_next;
  logic [15:0] err_sum;
  logic [15:0] cnt_sum;

  genvar gi, gj;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_vc
      noc_vc_route_fsm #(
        .COORD_W (COORD_W),
        .LOCAL_X (LOCAL_X),
        .LOCAL_Y (LOCAL_Y)
      ) u_fsm (
        .clk        (noc_clk),
        .srst       (noc_rst),
        .flit_valid (flit_valid_i[gi]),
        .flit_type  (flit_type_i[gi*2 +: 2]),
        .dest_x     (dest_x_i[gi*COORD_W +: COORD_W]),
        .dest_y     (dest_y_i[gi*COORD_W +: COORD_W]),
        .grant      (grant_vc[gi]),
        .flit_pop   (flit_pop_o[gi]),
        .sop        (sop_vc[gi]),
        .request    (request_vc[gi]),
        .eop        (eop_vc[gi]),
        .free       (free_vc[gi]),
        .out_sel    (out_sel_o[gi*NUM_PORTS +: NUM_PORTS]),
        .err        (err_vc[gi])
      );

      // [vc][port] inside the FSM <-> [port][vc] on the port interface.
      for (gj = 0; gj < NUM_PORTS; gj++) begin : g_port
        assign grant_vc[gi][gj]          = grant_i[gj*CHANNELS + gi];
        assign sop_o[gj*CHANNELS + gi]     = sop_vc[gi][gj];
        assign request_o[gj*CHANNELS + gi] = request_vc[gi][gj];
        assign eop_o[gj*CHANNELS + gi]     = eop_vc[gi][gj];
        assign free_o[gj*CHANNELS + gi]    = free_vc[gi][gj];
      end
    end
  endgenerate

  assign err_o = err_vc;

  // Several VCs may error in one cycle; add them all, then clip at 255.
  always_comb begin
    err_sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      err_sum = err_sum + 16'(err_vc[i]);
    end
    cnt_sum  = 16'(cnt_reg) + err_sum;
    cnt_next = (cnt_sum > 16'd255) ? 8'd255 : cnt_sum[7:0];
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) cnt_reg <= '0;
    else         cnt_reg <= cnt_next;
  end

  assign err_cnt_o = noc_rst ? 8'd0 : cnt_reg;

endmodule

// File: tb/tb_noc_input_port_requester.sv
module tb_noc_input_port_requester;

  localparam int CH = 2;
  localparam int PL = 0, PE = 1, PW = 2, PN = 3, PS = 4;
  localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;
  localparam logic [9:0] Z = 10'd0;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  flit_valid;
  logic [3:0]  flit_type;
  logic [7:0]  dest_x, dest_y;
  logic [1:0]  flit_pop;
  logic [9:0]  sop, request, grant, eop, free, out_sel;
  logic [1:0]  err;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  noc_input_port_requester #(
    .CHANNELS (CH),
    .COORD_W  (4),
    .LOCAL_X  (1),
    .LOCAL_Y  (1)
  ) dut (
    .noc_clk      (clk),
    .noc_rst      (rst),
    .flit_valid_i (flit_valid),
    .flit_type_i  (flit_type),
    .dest_x_i     (dest_x),
    .dest_y_i     (dest_y),
    .flit_pop_o   (flit_pop),
    .sop_o        (sop),
    .request_o    (request),
    .grant_i      (grant),
    .eop_o        (eop),
    .free_o       (free),
    .out_sel_o    (out_sel),
    .err_o        (err),
    .err_cnt_o    (err_cnt)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [1:0] valid;
    logic [3:0] ftype;
    logic [7:0] dx;
    logic [7:0] dy;
    logic [9:0] grant;
    logic [1:0] pop;
    logic [9:0] sop;
    logic [9:0] req;
    logic [9:0] eop;
    logic [9:0] free;
    logic [9:0] sel;
    logic [1:0] err;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // [port][vc] bit
  function automatic logic [9:0] pv(int p, int vc);
    return 10'd1 << (p*CH + vc);
  endfunction
  // out_sel [vc][port] bit
  function automatic logic [9:0] sl(int vc, int p);
    return 10'd1 << (vc*5 + p);
  endfunction
  function automatic logic [3:0] ft(logic [1:0] t0, logic [1:0] t1);
    return {t1, t0};
  endfunction
  function automatic logic [7:0] xy(int a0, int a1);
    return {4'(a1), 4'(a0)};
  endfunction

  task automatic add(input string name, input logic r, input logic [1:0] v,
                     input logic [3:0] t, input logic [7:0] x, input logic [7:0] y,
                     input logic [9:0] g, input logic [1:0] p, input logic [9:0] s,
                     input logic [9:0] q, input logic [9:0] e, input logic [9:0] f,
                     input logic [9:0] o, input logic [1:0] er, input logic [7:0] c);
    vec_t w;
    w.name = name; w.rst = r; w.valid = v; w.ftype = t; w.dx = x; w.dy = y;
    w.grant = g; w.pop = p; w.sop = s; w.req = q; w.eop = e; w.free = f;
    w.sel = o; w.err = er; w.cnt = c;
    vecs.push_back(w);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] e0, e1, s1, w0, n0, n1, l1;
    logic [61:0] act, exp;
    int exp_cnt;
    vec_t v;
    e0 = pv(PE, 0); e1 = pv(PE, 1); s1 = pv(PS, 1); w0 = pv(PW, 0);
    n0 = pv(PN, 0); n1 = pv(PN, 1); l1 = pv(PL, 1);

    // Reset: outputs quiet even with a body flit presented.
    add("rst_idle", 1, 2'b00, 0, 0, 0, Z, 0, Z, Z, Z, Z, Z, 0, 0);
    add("rst_body_gated", 1, 2'b01, ft(T_BODY, T_BODY), 0, 0, e0, 0, Z, Z, Z, Z, Z, 0, 0);
    // HEAD_TAIL to (3,1) -> EAST, grant held.
    add("t1_route", 0, 2'b01, ft(T_HT, 0), xy(3, 0), xy(1, 0), e0, 0, Z, Z, Z, Z, Z, 0, 0);
    add("t1_xfer", 0, 2'b01, ft(T_HT, 0), xy(3, 0), xy(1, 0), e0, 2'b01, e0, e0, e0, e0, sl(0, PE), 0, 0);
    add("t1_idle", 0, 2'b00, 0, 0, 0, e0, 0, Z, Z, Z, Z, Z, 0, 0);
    // VC1 four-flit packet to (1,0) -> SOUTH; grant withheld 3 cycles.
    add("t2_route", 0, 2'b10, ft(0, T_HEAD), xy(0, 1), xy(0, 0), Z, 0, Z, Z, Z, Z, Z, 0, 0);
    for (int k = 0; k < 3; k++)
      add("t2_wait", 0, 2'b10, ft(0, T_HEAD), xy(0, 1), xy(0, 0), Z, 0, s1, s1, Z, Z, sl(1, PS), 0, 0);
    add("t2_head", 0, 2'b10, ft(0, T_HEAD), xy(0, 1), xy(0, 0), s1, 2'b10, s1, s1, Z, Z, sl(1, PS), 0, 0);
    add("t2_body1", 0, 2'b10, ft(0, T_BODY), xy(0, 9), xy(0, 9), s1, 2'b10, s1, s1, Z, Z, sl(1, PS), 0, 0);
    add("t2_body2", 0, 2'b10, ft(0, T_BODY), xy(0, 0), xy(0, 5), s1, 2'b10, s1, s1, Z, Z, sl(1, PS), 0, 0);
    add("t2_tail", 0, 2'b10, ft(0, T_TAIL), 0, 0, s1, 2'b10, s1, s1, s1, s1, sl(1, PS), 0, 0);
    add("t2_idle", 0, 2'b00, 0, 0, 0, s1, 0, Z, Z, Z, Z, Z, 0, 0);
    // VC0 to (2,1) EAST: wrong-port grant, stray head, grant without request.
    add("t3_route", 0, 2'b01, ft(T_HEAD, 0), xy(2, 0), xy(1, 0), Z, 0, Z, Z, Z, Z, Z, 0, 0);
    add("t3_wrong_port", 0, 2'b01, ft(T_HEAD, 0), xy(2, 0), xy(1, 0), w0, 0, e0, e0, Z, Z, sl(0, PE), 0, 0);
    add("t3_head", 0, 2'b01, ft(T_HEAD, 0), xy(2, 0), xy(1, 0), e0, 2'b01, e0, e0, Z, Z, sl(0, PE), 0, 0);
    add("t3_extra_head", 0, 2'b01, ft(T_HEAD, 0), xy(0, 0), xy(0, 0), e0, 2'b01, e0, e0, Z, Z, sl(0, PE), 2'b01, 0);
    add("t3_grant_no_req", 0, 2'b00, 0, 0, 0, e0, 0, e0, Z, Z, Z, sl(0, PE), 0, 1);
    add("t3_tail", 0, 2'b01, ft(T_TAIL, 0), 0, 0, e0, 2'b01, e0, e0, e0, e0, sl(0, PE), 0, 1);
    add("t3_idle", 0, 2'b00, 0, 0, 0, Z, 0, Z, Z, Z, Z, Z, 0, 1);
    // VC0 -> EAST and VC1 -> LOCAL together, grants interleaved.
    add("t4_route", 0, 2'b11, ft(T_HEAD, T_HEAD), xy(3, 1), xy(1, 1), Z, 0, Z, Z, Z, Z, Z, 0, 1);
    add("t4_g_vc0", 0, 2'b11, ft(T_HEAD, T_HEAD), xy(3, 1), xy(1, 1), e0, 2'b01, e0|l1, e0|l1, Z, Z, sl(0, PE)|sl(1, PL), 0, 1);
    add("t4_g_vc1", 0, 2'b11, ft(T_TAIL, T_HEAD), 0, 0, l1, 2'b10, e0|l1, e0|l1, Z, Z, sl(0, PE)|sl(1, PL), 0, 1);
    add("t4_g_both", 0, 2'b11, ft(T_TAIL, T_TAIL), 0, 0, e0|l1, 2'b11, e0|l1, e0|l1, e0|l1, e0|l1, sl(0, PE)|sl(1, PL), 0, 1);
    add("t4_idle", 0, 2'b00, 0, 0, 0, Z, 0, Z, Z, Z, Z, Z, 0, 1);
    // Back-to-back HEAD_TAIL packets on VC0: NORTH then WEST, one bubble.
    add("t5_route_n", 0, 2'b01, ft(T_HT, 0), xy(1, 0), xy(2, 0), n0, 0, Z, Z, Z, Z, Z, 0, 1);
    add("t5_xfer_n", 0, 2'b01, ft(T_HT, 0), xy(1, 0), xy(2, 0), n0, 2'b01, n0, n0, n0, n0, sl(0, PN), 0, 1);
    add("t5_bubble", 0, 2'b01, ft(T_HT, 0), xy(0, 0), xy(1, 0), n0|w0, 0, Z, Z, Z, Z, Z, 0, 1);
    add("t5_xfer_w", 0, 2'b01, ft(T_HT, 0), xy(0, 0), xy(1, 0), n0|w0, 2'b01, w0, w0, w0, w0, sl(0, PW), 0, 1);
    add("t5_idle", 0, 2'b00, 0, 0, 0, Z, 0, Z, Z, Z, Z, Z, 0, 1);
    // Orphan flits in IDLE, including two errors in one cycle.
    add("t6_body", 0, 2'b01, ft(T_BODY, 0), 0, 0, Z, 2'b01, Z, Z, Z, Z, Z, 2'b01, 1);
    add("t6_double", 0, 2'b11, ft(T_TAIL, T_BODY), 0, 0, Z, 2'b11, Z, Z, Z, Z, Z, 2'b11, 2);
    add("t6_idle", 0, 2'b00, 0, 0, 0, Z, 0, Z, Z, Z, Z, Z, 0, 4);
    // Reset mid-packet on VC1 (EAST) after two body transfers.
    add("t7_route", 0, 2'b10, ft(0, T_HEAD), xy(0, 2), xy(0, 1), Z, 0, Z, Z, Z, Z, Z, 0, 4);
    add("t7_head", 0, 2'b10, ft(0, T_HEAD), xy(0, 2), xy(0, 1), e1, 2'b10, e1, e1, Z, Z, sl(1, PE), 0, 4);
    add("t7_body1", 0, 2'b10, ft(0, T_BODY), 0, 0, e1, 2'b10, e1, e1, Z, Z, sl(1, PE), 0, 4);
    add("t7_body2", 0, 2'b10, ft(0, T_BODY), 0, 0, e1, 2'b10, e1, e1, Z, Z, sl(1, PE), 0, 4);
    add("t7_reset", 1, 2'b10, ft(0, T_TAIL), 0, 0, e1, 0, Z, Z, Z, Z, Z, 0, 0);
    add("t7_after", 0, 2'b10, ft(0, T_HEAD), xy(0, 1), xy(0, 2), e1, 0, Z, Z, Z, Z, Z, 0, 0);
    add("t7_new_head", 0, 2'b10, ft(0, T_HEAD), xy(0, 1), xy(0, 2), n1, 2'b10, n1, n1, Z, Z, sl(1, PN), 0, 0);
    add("t7_new_tail", 0, 2'b10, ft(0, T_TAIL), 0, 0, n1, 2'b10, n1, n1, n1, n1, sl(1, PN), 0, 0);
    add("t7_idle", 0, 2'b00, 0, 0, 0, Z, 0, Z, Z, Z, Z, Z, 0, 0);
    // Saturation: 254 single errors, one double at 254, then 46 more.
    exp_cnt = 0;
    for (int k = 0; k < 254; k++) begin
      add("sat_body", 0, 2'b01, ft(T_BODY, 0), 0, 0, Z, 2'b01, Z, Z, Z, Z, Z, 2'b01, 8'(exp_cnt));
      exp_cnt = (exp_cnt + 1 > 255) ? 255 : exp_cnt + 1;
    end
    add("sat_double", 0, 2'b11, ft(T_BODY, T_TAIL), 0, 0, Z, 2'b11, Z, Z, Z, Z, Z, 2'b11, 8'(exp_cnt));
    exp_cnt = (exp_cnt + 2 > 255) ? 255 : exp_cnt + 2;
    for (int k = 0; k < 46; k++) begin
      add("sat_hold", 0, 2'b01, ft(T_BODY, 0), 0, 0, Z, 2'b01, Z, Z, Z, Z, Z, 2'b01, 8'(exp_cnt));
      exp_cnt = (exp_cnt + 1 > 255) ? 255 : exp_cnt + 1;
    end
    add("sat_final", 0, 2'b00, 0, 0, 0, Z, 0, Z, Z, Z, Z, Z, 0, 8'(exp_cnt));

    rst = 1'b1; flit_valid = '0; flit_type = '0; dest_x = '0; dest_y = '0; grant = '0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst = v.rst; flit_valid = v.valid; flit_type = v.ftype;
      dest_x = v.dx; dest_y = v.dy; grant = v.grant;
      sb.push_back(v);
      @(negedge clk);
      v = sb.pop_front();
      act = {flit_pop, sop, request, eop, free, out_sel, err, err_cnt};
      exp = {v.pop, v.sop, v.req, v.eop, v.free, v.sel, v.err, v.cnt};
      checks++;
      $display("vec %0d %s pop=%b sop=%b req=%b eop=%b sel=%b err=%b cnt=%0d",
               i, v.name, flit_pop, sop, request, eop, out_sel, err, err_cnt);
      if (act !== exp) begin
        errors++;
        $display("FAIL %s (vec %0d): actual {pop,sop,req,eop,free,sel,err,cnt}=%h required %h",
                 v.name, i, act, exp);
      end
      if (err_cnt !== v.cnt) begin
        $display("FAIL %s (vec %0d): err_cnt actual %0d required %0d",
                 v.name, i, err_cnt, v.cnt);
      end
      @(posedge clk); #1;
    end

    if (checks != vecs.size()) begin
      errors++;
      $display("FAIL only %0d of %0d vectors checked", checks, vecs.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    if (errors == 0) $display("PASS");
    else             $display("FAIL");
    $finish;
  end

endmodule
